// File: rtl/mux4_arbiter.sv
// Four-way round-robin arbiter with bounded hold time driving a 4:1 data mux.
// Grant, selects, busy and switch are registered; dout is muxed from live din.
module mux4_arbiter #(
  parameter int HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] din,
  output logic [3:0] gnt,
  output logic       s0,
  output logic       s1,
  output logic       busy,
  output logic       dout,
  output logic       switch
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

  state_t     state_q, state_d;
  logic       armed_q, armed_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] hold_q, hold_d;
  logic       switch_q, switch_d;

  logic       holder_req;
  logic       retain;
  logic [3:0] others;
  logic [3:0] cand;
  logic [1:0] winner;

  // First asserted bit of r, scanning p, p+1, p+2, p+3 modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic       found;
    rr_pick = p;
    found   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = p + 2'(i);
      if (r[idx] && !found) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  always_comb begin
    // NOTE: every _d gets a default first so no path through this block infers a latch.
    state_d  = state_q;
    gnt_d    = gnt_q;
    sel_d    = sel_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    switch_d = 1'b0;
    armed_d  = 1'b1;

    holder_req = (state_q == GRANT) && ((req & gnt_q) != 4'b0000);
    others     = req & ~gnt_q;
    retain     = holder_req && ((hold_q < HOLD_LIM) || (others == 4'b0000));
    cand       = holder_req ? others : req;
    winner     = rr_pick(cand, ptr_q);

    // The first edge after reset release only arms the arbiter.
    if (!armed_q) begin
      state_d = IDLE;
    end else if (retain) begin
      if (hold_q < HOLD_LIM) hold_d = hold_q + 4'd1;
    end else if (cand != 4'b0000) begin
      state_d  = GRANT;
      gnt_d    = 4'b0001 << winner;
      sel_d    = winner;
      ptr_d    = winner + 2'd1;
      hold_d   = 4'd1;
      switch_d = 1'b1;
    end else begin
      state_d = IDLE;
      gnt_d   = 4'b0000;
      hold_d  = 4'd0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  // NOTE: every flop is in the async reset; outputs must clear without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      armed_q  <= 1'b0;
      gnt_q    <= 4'b0000;
      sel_q    <= 2'd0;
      ptr_q    <= 2'd0;
      hold_q   <= 4'd0;
      switch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      armed_q  <= armed_d;
      gnt_q    <= gnt_d;
      sel_q    <= sel_d;
      ptr_q    <= ptr_d;
      hold_q   <= hold_d;
      switch_q <= switch_d;
    end
  end

  assign gnt    = gnt_q;
  assign s0     = sel_q[0];
  assign s1     = sel_q[1];
  assign busy   = (state_q == GRANT);
  assign switch = switch_q;
  assign dout   = busy ? din[sel_q] : 1'b0;

endmodule

// File: tb/tb_mux4_arbiter.sv
// Bench for mux4_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic against a rule-level model (HOLD_MAX=4 and HOLD_MAX=1).
module tb_mux4_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] din = 4'b0000;

  logic [3:0] gnt_w [2];
  logic       s0_w [2];
  logic       s1_w [2];
  logic       busy_w [2];
  logic       dout_w [2];
  logic       sw_w [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux4_arbiter #(.HOLD_MAX(4)) dut_h4 (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din), .gnt(gnt_w[0]),
    .s0(s0_w[0]), .s1(s1_w[0]), .busy(busy_w[0]), .dout(dout_w[0]), .switch(sw_w[0])
  );

  mux4_arbiter #(.HOLD_MAX(1)) dut_h1 (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din), .gnt(gnt_w[1]),
    .s0(s0_w[1]), .s1(s1_w[1]), .busy(busy_w[1]), .dout(dout_w[1]), .switch(sw_w[1])
  );

  // Observation layout: {gnt[3:0], s1, s0, busy, switch, dout}
  function automatic logic [8:0] mk(logic [3:0] g, int sel, logic b, logic s, logic d);
    logic [1:0] sl;
    sl = 2'(sel);
    return {g, sl[1], sl[0], b, s, d};
  endfunction

  function automatic logic [8:0] obs(int i);
    return {gnt_w[i], s1_w[i], s0_w[i], busy_w[i], sw_w[i], dout_w[i]};
  endfunction

  task automatic check(string name, logic [8:0] act, logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got gnt/s1s0/busy/sw/dout=%b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: arbitration rules stated directly, one call per clock edge.
  typedef struct {
    bit active;
    int holder;
    int cnt;
    int ptr;
    int sel;
    bit sw;
  } model_t;

  model_t m [2];
  int hold_of [2] = '{4, 1};

  function automatic model_t step(model_t s, logic [3:0] r, int h);
    logic [3:0] cand;
    logic [3:0] own;
    s.sw = 1'b0;
    own = s.active ? 4'(1 << s.holder) : 4'b0000;
    if (s.active && r[s.holder] && (s.cnt < h || (r & ~own) == 4'b0000)) begin
      if (s.cnt < h) s.cnt++;
      return s;
    end
    cand = (s.active && r[s.holder]) ? (r & ~own) : r;
    if (cand == 4'b0000) begin
      s.active = 1'b0;
      s.cnt = 0;
      return s;
    end
    for (int i = 0; i < 4; i++) begin
      int k;
      k = (s.ptr + i) % 4;
      if (cand[k]) begin
        s.holder = k;
        s.sel = k;
        s.cnt = 1;
        s.ptr = (k + 1) % 4;
        s.active = 1'b1;
        s.sw = 1'b1;
        return s;
      end
    end
    return s;
  endfunction

  function automatic logic [8:0] mexp(model_t s, logic [3:0] d);
    return mk(s.active ? 4'(1 << s.holder) : 4'b0000, s.sel, s.active, s.sw,
              s.active ? d[s.sel] : 1'b0);
  endfunction

  // Reset with requests asserted, release, and let the arming edge pass.
  task automatic do_reset();
    req = 4'b1111;
    din = 4'b1111;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold_h4", obs(0), 9'd0);
    check("reset_hold_h1", obs(1), 9'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    check("arm_edge_h4", obs(0), 9'd0);
    check("arm_edge_h1", obs(1), 9'd0);
    for (int i = 0; i < 2; i++) m[i] = '{active: 0, holder: 0, cnt: 0, ptr: 0, sel: 0, sw: 0};
  endtask

  task automatic apply(logic [3:0] r, logic [3:0] d);
    req = r;
    din = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [3:0] req;
    logic [3:0] din;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl [$];

  initial begin
    int idx;
    logic [3:0] d;

    // Directed table on HOLD_MAX=4: first grant, holder drop, idle retain, long single hold.
    tbl.push_back('{4'b0101, 4'b0101, mk(4'b0001, 0, 1, 1, 1)});
    tbl.push_back('{4'b1010, 4'b0000, mk(4'b0010, 1, 1, 1, 0)});
    tbl.push_back('{4'b1010, 4'b0010, mk(4'b0010, 1, 1, 0, 1)});
    tbl.push_back('{4'b0000, 4'b1111, mk(4'b0000, 1, 0, 0, 0)});
    tbl.push_back('{4'b0100, 4'b0100, mk(4'b0100, 2, 1, 1, 1)});
    for (int i = 1; i < 10; i++) begin
      d = (i % 2 == 1) ? 4'b1011 : 4'b0100;
      tbl.push_back('{4'b0100, d, mk(4'b0100, 2, 1, 0, d[2])});
    end
    tbl.push_back('{4'b1111, 4'b1000, mk(4'b1000, 3, 1, 1, 1)});
    tbl.push_back('{4'b0000, 4'b1111, mk(4'b0000, 3, 0, 0, 0)});

    do_reset();
    foreach (tbl[i]) begin
      apply(tbl[i].req, tbl[i].din);
      check($sformatf("table[%0d]", i), obs(0), tbl[i].exp);
    end

    // All four requesting: each index holds four cycles in rotation.
    do_reset();
    for (int c = 0; c < 20; c++) begin
      d = 4'($urandom_range(0, 15));
      apply(4'b1111, d);
      idx = (c / 4) % 4;
      check($sformatf("rr_hold4[%0d]", c), obs(0),
            mk(4'(1 << idx), idx, 1, (c % 4) == 0, d[idx]));
    end

    // HOLD_MAX=1 with two requesters alternates every cycle.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      apply(4'b0110, 4'b0010);
      idx = (c % 2 == 0) ? 1 : 2;
      check($sformatf("hold1_alt[%0d]", c), obs(1),
            mk(4'(1 << idx), idx, 1, 1, idx == 1));
    end

    // A request pulse between edges is never seen.
    do_reset();
    req = 4'b0001;
    #2 req = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    check("glitch_ignored", obs(0), 9'd0);

    // Reset mid-grant clears outputs without a clock; arbitration restarts at ptr 0.
    apply(4'b1111, 4'b1111);
    apply(4'b1111, 4'b1111);
    apply(4'b1111, 4'b1111);
    check("pre_reset_busy", obs(0), mk(4'b0001, 0, 1, 0, 1));
    #2 rst_n = 1'b0;
    #1;
    check("async_clear_h4", obs(0), 9'd0);
    check("async_clear_h1", obs(1), 9'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("no_grant_at_release", obs(0), 9'd0);
    @(posedge clk);
    @(negedge clk);
    check("first_grant_after_reset", obs(0), mk(4'b0001, 0, 1, 1, 1));

    // Randomized traffic against the model; requests tend to persist to exercise holds.
    do_reset();
    d = 4'b0000;
    for (int c = 0; c < 400; c++) begin
      logic [3:0] r;
      r = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : req;
      d = 4'($urandom_range(0, 15));
      apply(r, d);
      for (int i = 0; i < 2; i++) begin
        m[i] = step(m[i], r, hold_of[i]);
        check($sformatf("rand_h%0d[%0d]", hold_of[i], c), obs(i), mexp(m[i], d));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux4_arbiter.md
MUX4_ARBITER -- requirements
Module: mux4_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 4, is the maximum consecutive cycles one requester keeps the grant while others wait; legal range 1..15.
REQ-002 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port req  input  4  request lines; req[k] is requester k.
REQ-005 Port din  input  4  data bits; din[k] belongs to requester k (mux data inputs i0..i3).
REQ-006 Port gnt  output  4  one-hot grant, registered; all-zero when idle.
REQ-007 Port s0  output  1  mux select LSB, equal to the encoded grant index bit 0.
REQ-008 Port s1  output  1  mux select MSB, equal to the encoded grant index bit 1.
REQ-009 Port busy  output  1  high while any grant is active.
REQ-010 Port dout  output  1  din[{s1,s0}] while busy, 0 while idle; combinational from din and registered selects.
REQ-011 Port switch  output  1  one-cycle pulse in the first cycle a new grant index is presented.

Function
REQ-012 The FSM SHALL have two states: IDLE (gnt=0000, busy=0) and GRANT (exactly one gnt bit set, busy=1).
REQ-013 Latency: a request sampled at edge N in IDLE SHALL produce gnt, s1/s0 and busy at edge N (visible in cycle N+1); no combinational path from req to gnt.
REQ-014 Arbitration SHALL be round-robin: search starts at pointer ptr and proceeds ptr, ptr+1, ptr+2, ptr+3 modulo 4; the first asserted req wins.
REQ-015 On every new grant to index k, ptr SHALL update to (k+1) mod 4; ptr resets to 0.
REQ-016 In GRANT, while req[holder]=1 and hold count < HOLD_MAX, the grant SHALL be retained.
REQ-017 A hold counter SHALL load 1 on a new grant and increment each retained cycle, saturating at HOLD_MAX.
REQ-018 When hold count = HOLD_MAX and any other req bit is set, the grant SHALL move at the next edge to the round-robin winner among the other requesters.
REQ-019 When hold count = HOLD_MAX and no other req bit is set, the holder SHALL keep the grant, with no switch pulse and the counter held at HOLD_MAX.
REQ-020 When the holder drops req, at the next edge the grant SHALL go to the round-robin winner of the remaining requests, or to IDLE if req=0000.
REQ-021 In IDLE, s1/s0 SHALL retain the last granted index; dout SHALL be 0.
REQ-022 switch SHALL be 1 for exactly one cycle on IDLE->GRANT and on every GRANT->GRANT change of index; it SHALL be 0 on GRANT->IDLE.
REQ-023 HOLD_MAX=1 SHALL rotate the grant every cycle whenever two or more requests are active.
REQ-024 A req bit rising and falling between edges SHALL NOT be granted; only edge-sampled values count.

Reset
REQ-025 While rst_n=0, the block SHALL hold gnt=0000, s0=0, s1=0, busy=0, switch=0, dout=0, ptr=0, hold count=0 and state IDLE, independent of clk.
REQ-026 Reset asserted mid-grant SHALL clear all outputs immediately; after rst_n rises, the first edge SHALL arbitrate from ptr=0.
REQ-027 Deassertion of rst_n SHALL take effect at the first rising clk edge after it is sampled high; no grant SHALL be issued at or before that edge.

Verification
REQ-028 Reset, then req=0101 and din=0101: next cycle gnt=0001, s1s0=00, busy=1, switch=1, dout=1.
REQ-029 HOLD_MAX=4 with req=1111 held: grant sequence 0001 x4, 0010 x4, 0100 x4, 1000 x4, 0001 ..., with switch pulses at each change.
REQ-030 Only req[2] held for 10 cycles: gnt=0100 for all 10 cycles, switch high only in the first cycle, s1s0=10, dout=din[2].
REQ-031 Holder 0 drops req while req=1010: next cycle gnt=0010; after that holder drops and req=0000, next cycle gnt=0000, busy=0, s1s0=01 retained, dout=0.
REQ-032 rst_n pulsed low during GRANT with req=1111: outputs 0 without a clock edge; after release, first grant is gnt=0001.
REQ-033 HOLD_MAX=1 with req=0110: gnt alternates 0010, 0100 every cycle, with switch=1 every cycle.
